fbindct_wb_ctrl: RTL and testbench

FBINDCT_WB_CTRL -- requirements
Module: fbindct_wb_ctrl

---
 rtl/fbindct_wb_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_fbindct_wb_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbindct_wb_ctrl.sv
// fbindct_wb_ctrl -- DCT row write-back controller.
//
// Purpose:
//   Queues rows of DCT coefficients in a 2-entry row FIFO. Each row is written
//   to a BRAM port as WPR = ROW_DIM*COEF_WIDTH/DATA_WIDTH consecutive words.
//   After ROWS_PER_FRAME rows the output buffer flips between A and B and
//   ps_irq toggles.
//
// Ports:
//   clk, rst_n          - single clock, asynchronous active-low reset
//   dct_valid, dct_coef - row strobe and packed coefficients (coef 0 in LSBs)
//   frame_start,buf_sel - restart the frame into buffer A (0) or B (1); only
//                         taken while busy is low
//   bram_addr/wrdata/en/we - write-only BRAM port, driven during WRITE only
//   ps_irq              - toggles once per completed frame
//   busy                - FSM active or a row still queued
//   wb_ovf              - sticky row-drop flag (only with FBINDCT_WB_OVF_EN)
//
// Configuration macro: FBINDCT_WB_OVF_EN adds the wb_ovf output.

module fbindct_wb_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int ROW_DIM        = 8,
  parameter int COEF_WIDTH     = 16,
  parameter int ROWS_PER_FRAME = 256,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE_A = 13'h0800,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE_B = 13'h0C00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dct_valid,
  input  logic [ROW_DIM*COEF_WIDTH-1:0] dct_coef,
  input  logic                          frame_start,
  input  logic                          buf_sel,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_wrdata,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic                          ps_irq,
`ifdef FBINDCT_WB_OVF_EN
  output logic                          wb_ovf,
`endif
  output logic                          busy
);

  localparam int ROW_W = ROW_DIM * COEF_WIDTH;
  localparam int WPR   = ROW_W / DATA_WIDTH;
  localparam int WC_W  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RC_W  = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  // A row must split into a whole number of BRAM words.
  if ((ROW_W % DATA_WIDTH) != 0) begin : g_wpr_check
    $fatal(1, "fbindct_wb_ctrl: ROW_DIM*COEF_WIDTH must be a multiple of DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        mem_q [2];
  logic [ROW_W-1:0]        mem_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
  logic [RC_W-1:0]         row_cnt_q, row_cnt_d;
  logic                    buf_q, buf_d;
  logic                    ps_irq_q, ps_irq_d;
  logic                    busy_q, busy_d;
  logic                    bram_en_q, bram_en_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]   bram_wrdata_q, bram_wrdata_d;
  logic                    full_s, pop_s, push_s;
  logic [ROW_W-1:0]        head_s;
  logic [ADDR_WIDTH-1:0]   base_s;
`ifdef FBINDCT_WB_OVF_EN
  logic                    ovf_q, ovf_d;
  logic                    drop_s;
`endif

  // Next-state logic: FIFO, FSM, frame control and the registered BRAM port.
  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    word_cnt_d    = word_cnt_q;
    row_cnt_d     = row_cnt_q;
    buf_d         = buf_q;
    ps_irq_d      = ps_irq_q;
    bram_en_d     = 1'b0;
    bram_addr_d   = {ADDR_WIDTH{1'b0}};
    bram_wrdata_d = {DATA_WIDTH{1'b0}};
    head_s        = {ROW_W{1'b0}};
    base_s        = OUT_BASE_A;

    full_s = (cnt_q == 2'd2);
    pop_s  = (state_q == WRITE) && (word_cnt_q == WC_W'(WPR - 1));
    // A full FIFO still takes the row if the head leaves on this edge.
    push_s = dct_valid && (!full_s || pop_s);

    if (push_s) begin
      mem_d[wr_ptr_q] = dct_coef;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (cnt_q != 2'd0) begin
          state_d    = WRITE;
          word_cnt_d = {WC_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (pop_s) begin
          word_cnt_d = {WC_W{1'b0}};
          row_cnt_d  = row_cnt_q + RC_W'(1);
          if (row_cnt_q == RC_W'(ROWS_PER_FRAME - 1)) begin
            state_d = DONE;
          end else if (cnt_q == 2'd2) begin
            // Only rows queued before this edge continue back-to-back.
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          word_cnt_d = word_cnt_q + WC_W'(1);
        end
      end
      DONE: begin
        ps_irq_d  = ~ps_irq_q;
        row_cnt_d = {RC_W{1'b0}};
        buf_d     = ~buf_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Not busy implies IDLE with an empty FIFO, so nothing else touches
    // row_cnt or the buffer select this cycle.
    if (frame_start && !busy_q) begin
      buf_d     = buf_sel;
      row_cnt_d = {RC_W{1'b0}};
    end else begin
      buf_d = buf_d;
    end

    // BRAM outputs are registered, so they are built from next-cycle values.
    if (state_d == WRITE) begin
      base_s        = buf_d ? OUT_BASE_B : OUT_BASE_A;
      head_s        = mem_d[rd_ptr_d];
      bram_en_d     = 1'b1;
      bram_addr_d   = base_s + (ADDR_WIDTH'(row_cnt_d) * ADDR_WIDTH'(WPR))
                      + ADDR_WIDTH'(word_cnt_d);
      bram_wrdata_d = head_s[int'(word_cnt_d) * DATA_WIDTH +: DATA_WIDTH];
    end else begin
      bram_en_d     = 1'b0;
      bram_addr_d   = {ADDR_WIDTH{1'b0}};
      bram_wrdata_d = {DATA_WIDTH{1'b0}};
    end

    busy_d = (state_d != IDLE) || (cnt_d != 2'd0);
  end

`ifdef FBINDCT_WB_OVF_EN
  // Sticky drop flag, cleared by an honoured frame_start.
  always_comb begin
    drop_s = dct_valid && full_s && !pop_s;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (frame_start && !busy_q) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign wb_ovf = ovf_q;
`endif

  // State, FIFO and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_q[0]      <= {ROW_W{1'b0}};
      mem_q[1]      <= {ROW_W{1'b0}};
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
      word_cnt_q    <= {WC_W{1'b0}};
      row_cnt_q     <= {RC_W{1'b0}};
      buf_q         <= 1'b0;
      ps_irq_q      <= 1'b0;
      busy_q        <= 1'b0;
      bram_en_q     <= 1'b0;
      bram_addr_q   <= {ADDR_WIDTH{1'b0}};
      bram_wrdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      mem_q[0]      <= mem_d[0];
      mem_q[1]      <= mem_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      word_cnt_q    <= word_cnt_d;
      row_cnt_q     <= row_cnt_d;
      buf_q         <= buf_d;
      ps_irq_q      <= ps_irq_d;
      busy_q        <= busy_d;
      bram_en_q     <= bram_en_d;
      bram_addr_q   <= bram_addr_d;
      bram_wrdata_q <= bram_wrdata_d;
    end
  end

  assign bram_en     = bram_en_q;
  assign bram_we     = bram_en_q;
  assign bram_addr   = bram_addr_q;
  assign bram_wrdata = bram_wrdata_q;
  assign ps_irq      = ps_irq_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fbindct_wb_ctrl.sv
// Directed self-checking bench for fbindct_wb_ctrl (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_fbindct_wb_ctrl;

  logic         clk;
  logic         rst_n;
  logic         dct_valid;
  logic [127:0] dct_coef;
  logic         frame_start;
  logic         buf_sel;
  logic [12:0]  bram_addr;
  logic [31:0]  bram_wrdata;
  logic         bram_en;
  logic         bram_we;
  logic         ps_irq;
  logic         busy;
`ifdef FBINDCT_WB_OVF_EN
  logic         wb_ovf;
`endif

  int checks;
  int failures;

  fbindct_wb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dct_valid   (dct_valid),
    .dct_coef    (dct_coef),
    .frame_start (frame_start),
    .buf_sel     (buf_sel),
    .bram_addr   (bram_addr),
    .bram_wrdata (bram_wrdata),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .ps_irq      (ps_irq),
`ifdef FBINDCT_WB_OVF_EN
    .wb_ovf      (wb_ovf),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row whose coefficient j holds base+j.
  function automatic logic [127:0] mk_row(input int base);
    logic [127:0] r;
    r = 128'd0;
    for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(base + j);
    return r;
  endfunction

  // Expected word k of that row: coef 2k in the low half, 2k+1 in the high half.
  function automatic logic [31:0] exp_word(input int base, input int k);
    return {16'(base + 2*k + 1), 16'(base + 2*k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input int addr, input logic [31:0] data);
    chk({tag, "_en"}, {31'd0, bram_en}, 32'd1);
    chk({tag, "_we"}, {31'd0, bram_we}, 32'd1);
    chk({tag, "_addr"}, {19'd0, bram_addr}, 32'(addr));
    chk({tag, "_data"}, bram_wrdata, data);
  endtask

  task automatic chk_row(input string tag, input int addr0, input int base);
    for (int k = 0; k < 4; k++) begin
      chk_write(tag, addr0 + k, exp_word(base, k));
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    dct_valid = 1'b0;
    dct_coef = 128'd0;
    frame_start = 1'b0;
    buf_sel = 1'b0;
    #12;
    // Reset state
    chk("rst_en", {31'd0, bram_en}, 32'd0);
    chk("rst_we", {31'd0, bram_we}, 32'd0);
    chk("rst_addr", {19'd0, bram_addr}, 32'd0);
    chk("rst_data", bram_wrdata, 32'd0);
    chk("rst_irq", {31'd0, ps_irq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single row of coefs 0..7 into buffer A
    frame_start = 1'b1; buf_sel = 1'b0;
    tick();
    frame_start = 1'b0;
    dct_valid = 1'b1; dct_coef = mk_row(0);
    tick();
    dct_valid = 1'b0;
    chk("lat_n1_en", {31'd0, bram_en}, 32'd0);
    chk("lat_n1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk_write("r0w0", 13'h800, 32'h00010000);
    tick();
    chk_write("r0w1", 13'h801, 32'h00030002);
    tick();
    chk_write("r0w2", 13'h802, 32'h00050004);
    tick();
    chk_write("r0w3", 13'h803, 32'h00070006);
    tick();
    chk("r0_end_en", {31'd0, bram_en}, 32'd0);
    chk("r0_end_data", bram_wrdata, 32'd0);
    chk("r0_end_busy", {31'd0, busy}, 32'd0);
    tick();

    // Three consecutive rows while idle: third dropped
`ifdef FBINDCT_WB_OVF_EN
    chk("ovf_pre", {31'd0, wb_ovf}, 32'd0);
`endif
    dct_valid = 1'b1; dct_coef = mk_row(16);
    tick();
    dct_coef = mk_row(32);
    tick();
    chk_write("d1w0", 13'h804, exp_word(16, 0));
    dct_coef = mk_row(48);
    tick();
    dct_valid = 1'b0;
    chk_write("d1w1", 13'h805, exp_word(16, 1));
    tick();
    chk_write("d1w2", 13'h806, exp_word(16, 2));
    tick();
    chk_write("d1w3", 13'h807, exp_word(16, 3));
    tick();
    chk_row("d2", 13'h808, 32);
    chk("drop_end_en", {31'd0, bram_en}, 32'd0);
    chk("drop_end_busy", {31'd0, busy}, 32'd0);
`ifdef FBINDCT_WB_OVF_EN
    chk("ovf_set", {31'd0, wb_ovf}, 32'd1);
`endif
    tick();

    // Restart frame in A, clearing row_cnt (and the overflow flag)
    frame_start = 1'b1; buf_sel = 1'b0;
    tick();
    frame_start = 1'b0;
`ifdef FBINDCT_WB_OVF_EN
    chk("ovf_clr", {31'd0, wb_ovf}, 32'd0);
`endif
    // Push on the last-word pop while full: accepted
    dct_valid = 1'b1; dct_coef = mk_row(64);
    tick();
    dct_coef = mk_row(80);
    tick();
    dct_valid = 1'b0;
    chk_write("f0w0", 13'h800, exp_word(64, 0));
    tick();
    chk_write("f0w1", 13'h801, exp_word(64, 1));
    tick();
    chk_write("f0w2", 13'h802, exp_word(64, 2));
    tick();
    chk_write("f0w3", 13'h803, exp_word(64, 3));
    dct_valid = 1'b1; dct_coef = mk_row(96);
    tick();
    dct_valid = 1'b0;
    chk_row("f1", 13'h804, 80);
    chk_row("f2", 13'h808, 96);
    chk("full_end_en", {31'd0, bram_en}, 32'd0);
`ifdef FBINDCT_WB_OVF_EN
    chk("ovf_nodrop", {31'd0, wb_ovf}, 32'd0);
`endif
    tick();

    // Reset at word 2 with a second row queued
    dct_valid = 1'b1; dct_coef = mk_row(112);
    tick();
    dct_coef = mk_row(128);
    tick();
    dct_valid = 1'b0;
    tick();
    tick();
    chk_write("pre_rst_w2", 13'h80E, exp_word(112, 2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, bram_en}, 32'd0);
    chk("arst_we", {31'd0, bram_we}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_irq", {31'd0, ps_irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_en", {31'd0, bram_en}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    dct_valid = 1'b1; dct_coef = mk_row(200);
    tick();
    dct_valid = 1'b0;
    tick();
    chk_row("post_rst", 13'h800, 200);
    tick();

    // Full frame of 256 rows, 10 cycles apart, continuing from row 1
    for (int i = 1; i < 256; i++) begin
      dct_valid = 1'b1; dct_coef = mk_row(i * 8);
      tick();
      dct_valid = 1'b0;
      tick();
      if (i == 255) chk("irq_before", {31'd0, ps_irq}, 32'd0);
      chk_row("frame", 13'h800 + 4 * i, i * 8);
      for (int c = 0; c < 4; c++) tick();
    end
    chk("irq_toggle", {31'd0, ps_irq}, 32'd1);
    chk("frame_busy", {31'd0, busy}, 32'd0);
    dct_valid = 1'b1; dct_coef = mk_row(300);
    tick();
    dct_valid = 1'b0;
    tick();
    chk_row("bufB", 13'hC00, 300);
    tick();
    tick();

    // frame_start ignored while busy, honoured when idle
    frame_start = 1'b1; buf_sel = 1'b0;
    tick();
    frame_start = 1'b0;
    dct_valid = 1'b1; dct_coef = mk_row(400);
    tick();
    dct_valid = 1'b0;
    tick();
    chk_write("ign_w0", 13'h800, exp_word(400, 0));
    frame_start = 1'b1; buf_sel = 1'b1;
    tick();
    frame_start = 1'b0; buf_sel = 1'b0;
    chk_write("ign_w1", 13'h801, exp_word(400, 1));
    tick();
    tick();
    tick();
    dct_valid = 1'b1; dct_coef = mk_row(500);
    tick();
    dct_valid = 1'b0;
    tick();
    chk_row("ign_next", 13'h804, 500);
    tick();
    frame_start = 1'b1; buf_sel = 1'b1;
    tick();
    frame_start = 1'b0; buf_sel = 1'b0;
    dct_valid = 1'b1; dct_coef = mk_row(600);
    tick();
    dct_valid = 1'b0;
    tick();
    chk_row("fs_B", 13'hC00, 600);
    chk("final_en", {31'd0, bram_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
